// File: rtl/dmem_mmio.sv
// dmem_mmio: data RAM plus memory-mapped UART TX, LED register and cycle counter,
// placed directly after the CPU memory stage.
//   clk, rst    : clock, synchronous active-low reset
//   A, WD, WE   : byte address (A[1:0] ignored), store data, store strobe
//   RD          : combinational load data for the current A
//   uart_tx     : 8N1 serial output, idles high
//   leds        : LED register contents
module dmem_mmio #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] DATA_BASE    = 32'h1001_0000,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        uart_tx,
  output logic [7:0]  leds
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned BW        = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Address decode on the word-aligned address
  logic [31:0]   addr_w;
  logic [31:0]   ram_off;
  logic [AW-1:0] ram_idx;
  logic          ram_hit, sel_tx, sel_status, sel_led, sel_cycles;
  logic [1:0]    unused_a;

  assign unused_a   = A[1:0];
  assign addr_w     = {A[31:2], 2'b00};
  // Unsigned offset compare also rejects addresses below DATA_BASE (they wrap high)
  assign ram_off    = addr_w - DATA_BASE;
  assign ram_hit    = ram_off < RAM_BYTES;
  assign ram_idx    = ram_off[AW+1:2];
  assign sel_tx     = addr_w == MMIO_BASE;
  assign sel_status = addr_w == (MMIO_BASE + 32'd4);
  assign sel_led    = addr_w == (MMIO_BASE + 32'd8);
  assign sel_cycles = addr_w == (MMIO_BASE + 32'd12);

  // Data RAM: synchronous write, asynchronous read, never reset
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (WE && ram_hit) mem[ram_idx] <= WD;
  end

  // UART transmitter state
  uart_state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          overrun, overrun_n;
  logic [31:0]   cycles;
  logic          tx_wr, baud_done;

  assign tx_wr     = WE && sel_tx;
  assign baud_done = baud == BAUD_LAST;

  // Next-state logic; uart_tx is registered from the next state so the line
  // changes in the same cycle the new state becomes visible
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    overrun_n = overrun;
    tx_n      = 1'b1;

    case (state)
      IDLE: begin
        if (tx_wr) begin
          state_n = START;
          baud_n  = '0;
          shift_n = WD[7:0];
        end
      end
      START: begin
        if (baud_done) begin
          state_n   = DATA;
          baud_n    = '0;
          bit_idx_n = 3'd0;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n    = '0;
          shift_n   = {1'b0, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          state_n = IDLE;
          baud_n  = '0;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // A TXDATA write is only accepted in IDLE; anything else is an overrun
    if (tx_wr && (state != IDLE)) overrun_n = 1'b1;
    else if (WE && sel_status && WD[1]) overrun_n = 1'b0;

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      uart_tx <= 1'b1;
      overrun <= 1'b0;
      leds    <= 8'd0;
      cycles  <= 32'd0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      uart_tx <= tx_n;
      overrun <= overrun_n;
      if (WE && sel_led) leds <= WD[7:0];
      cycles  <= cycles + 32'd1;
    end
  end

  // Load data mux
  always_comb begin
    RD = 32'd0;
    if (ram_hit)         RD = mem[ram_idx];
    else if (sel_status) RD = {30'd0, overrun, state != IDLE};
    else if (sel_led)    RD = {24'd0, leds};
    else if (sel_cycles) RD = cycles;
  end

endmodule
